wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Arbitrates the single register-file write port between the in-order WB stage and a long-latency
//  unit (LU: mult/div/cop results). Pipeline WB always wins; LU results queue in a small FIFO and
//  drain into idle WB slots. Also squashes stale (WAW) entries, flags pending-register hazards to ID
//  and requests a stall when an entry starves. Sits between the MEM/WB latch + WB mux and regfile.
// PARAMETERS
//  DATA_WIDTH      32  register data width (`DATA_WIDTH)
//  REG_ADDR_WIDTH  5   register address width (`REG_ADDR_WIDTH)
//  FIFO_DEPTH      2   LU result queue entries (power of 2, >=2)
//  MAX_WAIT        4   cycles a valid head may wait before stall_req_out is raised (>=1)
// PORTS
//  clk                   in   1    clock, all state on posedge
//  reset                 in   1    asynchronous, active-high; clears all state
//  wb_reg_write_in       in   1    WB-stage write enable (after MEM/WB latch)
//  wb_write_register_in  in   5    WB-stage destination register
//  wb_write_data_in      in   32   WB-stage data (post mem_to_reg / JAL mux)
//  lu_valid_in           in   1    LU result valid
//  lu_write_register_in  in   5    LU destination register
//  lu_write_data_in      in   32   LU result data
//  lu_ready_out          out  1    queue can accept (transfer = lu_valid_in & lu_ready_out)
//  query_rs_in           in   5    ID-stage source rs
//  query_rt_in           in   5    ID-stage source rt
//  pending_hit_out       out  1    rs or rt (nonzero) matches a valid queued entry
//  rf_write_en_out       out  1    regfile write enable
//  rf_write_addr_out     out  5    regfile write address
//  rf_write_data_out     out  32   regfile write data
//  stall_req_out         out  1    registered request to hazard unit to bubble MEM/WB
//  pending_count_out     out  2    occupied entries (valid or killed), $clog2(FIFO_DEPTH)+1 bits
// BEHAVIOUR
//  - Reset (async): queue empty, all valid bits 0, wait counter 0, stall_req_out 0. While reset high
//    rf_write_en_out=0, lu_ready_out=0, pending_hit_out=0, pending_count_out=0; addr/data outputs 0.
//  - wb_busy = wb_reg_write_in & (wb_write_register_in != 0). Write-port muxing is combinational,
//    zero latency:
//    wb_busy                    -> rf_* = wb_* inputs, en=1.
//    !wb_busy & head valid      -> rf_* = head entry, en=1, head popped at clock edge.
//    !wb_busy & head killed     -> en=0, head popped (discarded) at clock edge.
//    otherwise                  -> en=0, addr/data 0.
//  - Killed head is also popped while wb_busy (discard needs no port); valid head never popped then.
//  - lu_ready_out = !full (no same-cycle pop bypass). lu_valid_in while full is ignored; LU holds.
//  - LU transfer with lu_write_register_in==0: accepted, not enqueued (dropped).
//  - WAW squash: when wb_busy, every queued entry whose addr == wb_write_register_in has its valid
//    bit cleared at the edge. An entry enqueued in the same cycle is NOT squashed (LU result younger).
//  - Push and pop in the same cycle: both take effect; count unchanged. Pointers wrap modulo DEPTH.
//  - Wait counter: +1 per cycle a valid head exists and is not popped; 0 on pop, squash of head or
//    empty; saturates at MAX_WAIT. stall_req_out <= (counter_next >= MAX_WAIT); drops the cycle after
//    the starving head is popped or killed.
//  - pending_hit_out combinational over stored valid entries only; query of reg 0 never hits.
// STRUCTURE
//  - mips_pkg.vh: `DATA_WIDTH, `REG_ADDR_WIDTH, `CTRL_REG_WRITE_EN/_DIS, `WB_FIFO_DEPTH,
//    `WB_MAX_WAIT defaults.
//  - Sub-module wb_pending_fifo: storage, rd/wr pointers, per-entry valid bit, parallel addr compare
//    (squash + query). Top: grant mux, wait counter, stall register.
// TESTING
//  1. LU push r8=0x1234, WB idle -> next cycle rf_en=1 addr=8 data=0x1234; count 1->0.
//  2. WB writes r3 every cycle, LU pushes r9 -> no LU write; stall_req_out=1 after 4 waiting cycles;
//     WB bubble -> r9 written, stall_req_out=0 next cycle.
//  3. Queue r5=0xAA, then WB writes r5=0xBB -> entry killed; regfile never sees 0xAA; count reaches 0.
//  4. Fill 2 entries -> lu_ready_out=0, extra lu_valid ignored; pop one -> ready=1 next cycle.
//  5. Queued r7; query_rs=7 -> pending_hit=1; query rs=0, rt=6 -> 0; LU push r0 -> count stays 0.
//  6. Assert reset asynchronously mid-drain (count=2, stall=1) -> all outputs 0 before next edge.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, defaults and grant encoding for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int WB_FIFO_DEPTH  = 2;
  localparam int WB_MAX_WAIT    = 4;

  localparam logic CTRL_REG_WRITE_EN  = 1'b1;
  localparam logic CTRL_REG_WRITE_DIS = 1'b0;

  typedef enum logic [1:0] {
    GRANT_NONE    = 2'd0,
    GRANT_WB      = 2'd1,
    GRANT_LU      = 2'd2,
    GRANT_DISCARD = 2'd3
  } grant_e;

endpackage

// File: rtl/wb_pending_fifo.sv
// Queue of pending long-latency results with per-entry valid bits and
// parallel address compare for WAW squash and ID-stage hazard queries.
module wb_pending_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH,
  parameter int AW    = REG_ADDR_WIDTH,
  parameter int DW    = DATA_WIDTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          squash_en,
  input  logic [AW-1:0] squash_addr,
  input  logic [AW-1:0] query_rs,
  input  logic [AW-1:0] query_rt,
  output logic          full,
  output logic          empty,
  output logic          head_valid,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [CW-1:0] count,
  output logic          pending_hit
);

  logic [AW-1:0] addr_q  [DEPTH];
  logic [AW-1:0] addr_d  [DEPTH];
  logic [DW-1:0] data_q  [DEPTH];
  logic [DW-1:0] data_d  [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Squash is applied before the push so a same-cycle enqueue survives.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (squash_en && addr_q[i] == squash_addr) valid_d[i] = 1'b0;
    end
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      addr_d[wr_ptr_q]  = push_addr;
      data_d[wr_ptr_q]  = push_data;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    pending_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (((query_rs != '0) && (addr_q[i] == query_rs)) ||
                         ((query_rt != '0) && (addr_q[i] == query_rt))))
        pending_hit = 1'b1;
    end
  end

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign head_valid = valid_q[rd_ptr_q];
  assign head_addr  = addr_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: WB stage always wins, queued LU results
// drain into idle slots, and a starving queue head raises a stall request.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH_P     = DATA_WIDTH,
  parameter int REG_ADDR_WIDTH_P = REG_ADDR_WIDTH,
  parameter int FIFO_DEPTH       = WB_FIFO_DEPTH,
  parameter int MAX_WAIT         = WB_MAX_WAIT,
  localparam int CW              = $clog2(FIFO_DEPTH) + 1,
  localparam int WW              = $clog2(MAX_WAIT + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wb_reg_write_in,
  input  logic [REG_ADDR_WIDTH_P-1:0] wb_write_register_in,
  input  logic [DATA_WIDTH_P-1:0]     wb_write_data_in,
  input  logic                        lu_valid_in,
  input  logic [REG_ADDR_WIDTH_P-1:0] lu_write_register_in,
  input  logic [DATA_WIDTH_P-1:0]     lu_write_data_in,
  output logic                        lu_ready_out,
  input  logic [REG_ADDR_WIDTH_P-1:0] query_rs_in,
  input  logic [REG_ADDR_WIDTH_P-1:0] query_rt_in,
  output logic                        pending_hit_out,
  output logic                        rf_write_en_out,
  output logic [REG_ADDR_WIDTH_P-1:0] rf_write_addr_out,
  output logic [DATA_WIDTH_P-1:0]     rf_write_data_out,
  output logic                        stall_req_out,
  output logic [CW-1:0]               pending_count_out
);

  logic wb_busy, lu_push, pop, head_squash;
  logic full, empty, head_valid, pending_hit;
  logic [REG_ADDR_WIDTH_P-1:0] head_addr;
  logic [DATA_WIDTH_P-1:0]     head_data;
  logic [CW-1:0]               count;
  logic [WW-1:0] wait_q, wait_d;
  logic          stall_q, stall_d;
  grant_e        grant;

  assign wb_busy      = wb_reg_write_in && (wb_write_register_in != '0);
  assign lu_ready_out = !full && !reset;
  assign lu_push      = lu_valid_in && lu_ready_out && (lu_write_register_in != '0);

  wb_pending_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (REG_ADDR_WIDTH_P),
    .DW    (DATA_WIDTH_P)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (lu_push),
    .push_addr   (lu_write_register_in),
    .push_data   (lu_write_data_in),
    .pop         (pop),
    .squash_en   (wb_busy),
    .squash_addr (wb_write_register_in),
    .query_rs    (query_rs_in),
    .query_rt    (query_rt_in),
    .full        (full),
    .empty       (empty),
    .head_valid  (head_valid),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (count),
    .pending_hit (pending_hit)
  );

  // A killed head is discarded even while WB owns the port.
  always_comb begin
    grant = GRANT_NONE;
    if (wb_busy)         grant = GRANT_WB;
    else if (head_valid) grant = GRANT_LU;
    else if (!empty)     grant = GRANT_DISCARD;
    pop = !empty && (!head_valid || !wb_busy);
  end

  always_comb begin
    rf_write_en_out   = CTRL_REG_WRITE_DIS;
    rf_write_addr_out = '0;
    rf_write_data_out = '0;
    if (!reset) begin
      case (grant)
        GRANT_WB: begin
          rf_write_en_out   = CTRL_REG_WRITE_EN;
          rf_write_addr_out = wb_write_register_in;
          rf_write_data_out = wb_write_data_in;
        end
        GRANT_LU: begin
          rf_write_en_out   = CTRL_REG_WRITE_EN;
          rf_write_addr_out = head_addr;
          rf_write_data_out = head_data;
        end
        default: ;
      endcase
    end
  end

  assign head_squash = head_valid && wb_busy && (head_addr == wb_write_register_in);

  always_comb begin
    wait_d = wait_q;
    if (!head_valid || pop || head_squash) wait_d = '0;
    else if (wait_q < WW'(MAX_WAIT))       wait_d = wait_q + WW'(1);
    stall_d = (wait_d >= WW'(MAX_WAIT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign stall_req_out     = stall_q;
  assign pending_hit_out   = pending_hit && !reset;
  assign pending_count_out = reset ? '0 : count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_reg_write_in;
  logic [4:0]  wb_write_register_in;
  logic [31:0] wb_write_data_in;
  logic        lu_valid_in;
  logic [4:0]  lu_write_register_in;
  logic [31:0] lu_write_data_in;
  logic        lu_ready_out;
  logic [4:0]  query_rs_in;
  logic [4:0]  query_rt_in;
  logic        pending_hit_out;
  logic        rf_write_en_out;
  logic [4:0]  rf_write_addr_out;
  logic [31:0] rf_write_data_out;
  logic        stall_req_out;
  logic [1:0]  pending_count_out;

  int tests_run = 0;
  int tests_failed = 0;

  wb_port_arbiter dut (
    .clk                  (clk),
    .reset                (reset),
    .wb_reg_write_in      (wb_reg_write_in),
    .wb_write_register_in (wb_write_register_in),
    .wb_write_data_in     (wb_write_data_in),
    .lu_valid_in          (lu_valid_in),
    .lu_write_register_in (lu_write_register_in),
    .lu_write_data_in     (lu_write_data_in),
    .lu_ready_out         (lu_ready_out),
    .query_rs_in          (query_rs_in),
    .query_rt_in          (query_rt_in),
    .pending_hit_out      (pending_hit_out),
    .rf_write_en_out      (rf_write_en_out),
    .rf_write_addr_out    (rf_write_addr_out),
    .rf_write_data_out    (rf_write_data_out),
    .stall_req_out        (stall_req_out),
    .pending_count_out    (pending_count_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic wb_we, input logic [4:0] wb_reg,
                                input logic [31:0] wb_data, input logic lu_v,
                                input logic [4:0] lu_reg, input logic [31:0] lu_data);
    wb_reg_write_in      = wb_we;
    wb_write_register_in = wb_reg;
    wb_write_data_in     = wb_data;
    lu_valid_in          = lu_v;
    lu_write_register_in = lu_reg;
    lu_write_data_in     = lu_data;
  endtask

  initial begin
    reset       = 1'b1;
    query_rs_in = 5'd0;
    query_rt_in = 5'd0;
    apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h1234);
    #12;
    check_output("reset_rf_en",  32'(rf_write_en_out), 32'd0);
    check_output("reset_addr",   32'(rf_write_addr_out), 32'd0);
    check_output("reset_ready",  32'(lu_ready_out), 32'd0);
    check_output("reset_count",  32'(pending_count_out), 32'd0);
    check_output("reset_stall",  32'(stall_req_out), 32'd0);

    tick();
    reset = 1'b0;
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Single LU result drains into the next idle slot
    tick();
    apply_stimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h1234);
    #1;
    check_output("t1_ready", 32'(lu_ready_out), 32'd1);
    check_output("t1_en_before", 32'(rf_write_en_out), 32'd0);
    tick();
    lu_valid_in = 1'b0;
    #1;
    check_output("t1_en",    32'(rf_write_en_out), 32'd1);
    check_output("t1_addr",  32'(rf_write_addr_out), 32'd8);
    check_output("t1_data",  rf_write_data_out, 32'h1234);
    check_output("t1_count1", 32'(pending_count_out), 32'd1);
    tick();
    check_output("t1_count0", 32'(pending_count_out), 32'd0);
    check_output("t1_en_after", 32'(rf_write_en_out), 32'd0);

    // Starvation behind continuous WB writes
    apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h99);
    tick();
    lu_valid_in = 1'b0;
    #1;
    check_output("t2_wb_addr", 32'(rf_write_addr_out), 32'd3);
    check_output("t2_wb_data", rf_write_data_out, 32'h33);
    check_output("t2_count", 32'(pending_count_out), 32'd1);
    check_output("t2_stall0", 32'(stall_req_out), 32'd0);
    tick();
    check_output("t2_stall_w1", 32'(stall_req_out), 32'd0);
    tick();
    check_output("t2_stall_w2", 32'(stall_req_out), 32'd0);
    tick();
    check_output("t2_stall_w3", 32'(stall_req_out), 32'd0);
    tick();
    check_output("t2_stall_w4", 32'(stall_req_out), 32'd1);
    wb_reg_write_in = 1'b0;
    #1;
    check_output("t2_lu_en",   32'(rf_write_en_out), 32'd1);
    check_output("t2_lu_addr", 32'(rf_write_addr_out), 32'd9);
    check_output("t2_lu_data", rf_write_data_out, 32'h99);
    tick();
    check_output("t2_stall_drop", 32'(stall_req_out), 32'd0);
    check_output("t2_count0", 32'(pending_count_out), 32'd0);

    // WAW squash; an entry pushed alongside a matching WB write survives
    apply_stimulus(1'b1, 5'd5, 32'hBB, 1'b1, 5'd5, 32'hAA);
    query_rs_in = 5'd5;
    tick();
    lu_valid_in = 1'b0;
    #1;
    check_output("t3_survive_hit", 32'(pending_hit_out), 32'd1);
    check_output("t3_wb_data", rf_write_data_out, 32'hBB);
    tick();
    wb_reg_write_in = 1'b0;
    #1;
    check_output("t3_killed_en", 32'(rf_write_en_out), 32'd0);
    check_output("t3_killed_hit", 32'(pending_hit_out), 32'd0);
    check_output("t3_killed_count", 32'(pending_count_out), 32'd1);
    tick();
    check_output("t3_count0", 32'(pending_count_out), 32'd0);
    check_output("t3_en_after", 32'(rf_write_en_out), 32'd0);
    query_rs_in = 5'd0;

    // Full queue back-pressure, then simultaneous push and pop
    apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA0);
    tick();
    apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd11, 32'hB0);
    tick();
    apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hC0);
    #1;
    check_output("t4_full_ready", 32'(lu_ready_out), 32'd0);
    check_output("t4_full_count", 32'(pending_count_out), 32'd2);
    tick();
    check_output("t4_ignored_count", 32'(pending_count_out), 32'd2);
    wb_reg_write_in = 1'b0;
    #1;
    check_output("t4_head_addr", 32'(rf_write_addr_out), 32'd10);
    check_output("t4_head_data", rf_write_data_out, 32'hA0);
    check_output("t4_no_bypass", 32'(lu_ready_out), 32'd0);
    tick();
    check_output("t4_ready_back", 32'(lu_ready_out), 32'd1);
    check_output("t4_count1", 32'(pending_count_out), 32'd1);
    check_output("t4_second_addr", 32'(rf_write_addr_out), 32'd11);
    tick();
    lu_valid_in = 1'b0;
    #1;
    check_output("t4_pushpop_count", 32'(pending_count_out), 32'd1);
    check_output("t4_third_addr", 32'(rf_write_addr_out), 32'd12);
    check_output("t4_third_data", rf_write_data_out, 32'hC0);
    tick();
    check_output("t4_count0", 32'(pending_count_out), 32'd0);

    // Pending-register queries and the r0 drop
    apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
    tick();
    lu_valid_in = 1'b0;
    query_rs_in = 5'd7;
    query_rt_in = 5'd0;
    #1;
    check_output("t5_hit_rs", 32'(pending_hit_out), 32'd1);
    query_rs_in = 5'd0;
    query_rt_in = 5'd6;
    #1;
    check_output("t5_miss", 32'(pending_hit_out), 32'd0);
    query_rt_in = 5'd7;
    #1;
    check_output("t5_hit_rt", 32'(pending_hit_out), 32'd1);
    apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd0, 32'hDEAD);
    tick();
    lu_valid_in = 1'b0;
    #1;
    check_output("t5_r0_dropped", 32'(pending_count_out), 32'd1);
    wb_reg_write_in = 1'b0;
    tick();
    check_output("t5_count0", 32'(pending_count_out), 32'd0);
    query_rt_in = 5'd0;

    // Asynchronous reset mid-drain with a full, starving queue
    apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd20, 32'h200);
    tick();
    apply_stimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd21, 32'h210);
    tick();
    lu_valid_in = 1'b0;
    tick();
    tick();
    tick();
    query_rs_in = 5'd21;
    wb_reg_write_in = 1'b0;
    #1;
    check_output("t6_pre_count", 32'(pending_count_out), 32'd2);
    check_output("t6_pre_stall", 32'(stall_req_out), 32'd1);
    check_output("t6_pre_addr", 32'(rf_write_addr_out), 32'd20);
    check_output("t6_pre_hit", 32'(pending_hit_out), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_output("t6_rst_en", 32'(rf_write_en_out), 32'd0);
    check_output("t6_rst_addr", 32'(rf_write_addr_out), 32'd0);
    check_output("t6_rst_data", rf_write_data_out, 32'd0);
    check_output("t6_rst_ready", 32'(lu_ready_out), 32'd0);
    check_output("t6_rst_hit", 32'(pending_hit_out), 32'd0);
    check_output("t6_rst_count", 32'(pending_count_out), 32'd0);
    check_output("t6_rst_stall", 32'(stall_req_out), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_output("t6_post_ready", 32'(lu_ready_out), 32'd1);
    check_output("t6_post_en", 32'(rf_write_en_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout: observed no finish, expected finish before 20000");
    $fatal(1, "[TB] timeout");
  end

endmodule
